mesh_ctrl: RTL and testbench

Sequencer for the systolic matrix-vector `mesh`. On a `start` pulse it runs one or more matrix-vector passes:
- streams the source vector bank and the matrix banks into the mesh;
- generates the per-node skewed clear strobes (`csels`);
- waits for the pipeline to drain;
- writes each node's result into the opposite vector bank, ping-ponging banks between passes.

It sits between the AXI-lite command registers and the `mesh` + BRAM group.

---
 rtl/mesh_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_mesh_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_ctrl.sv
// mesh_ctrl: pass sequencer for the systolic matrix-vector mesh.
// Streams the source vector and matrix columns, produces skewed csels clear
// strobes, waits for the pipeline to drain, then writes node results into the
// opposite vector bank. Multiple passes ping-pong between the two banks.
module mesh_ctrl #(
  parameter int IDX_WIDTH_FOR_NODES = 6,
  parameter int NUM_NODES           = 2**IDX_WIDTH_FOR_NODES,
  parameter int ADDR_WIDTH          = 10,
  parameter int RD_LAT              = 1,
  parameter int NODE_LAT            = 3
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          cfg_len_m1,
  input  logic [7:0]                     cfg_iters,
  input  logic                           cfg_src,
  input  logic                           cfg_use_init,
  output logic                           busy,
  output logic                           done,
  output logic                           mbram_en,
  output logic [ADDR_WIDTH-1:0]          mbram_addr,
  output logic                           vbram0_en,
  output logic                           vbram0_we,
  output logic [ADDR_WIDTH-1:0]          vbram0_addr,
  output logic                           vbram1_en,
  output logic                           vbram1_we,
  output logic [ADDR_WIDTH-1:0]          vbram1_addr,
  output logic [1:0]                     asel,
  output logic [NUM_NODES-1:0]           csels,
  output logic [IDX_WIDTH_FOR_NODES-1:0] ressel,
  output logic [1:0]                     dinsel,
  output logic [7:0]                     cur_iter
);

  localparam int DRAIN_CYC = RD_LAT + NUM_NODES + NODE_LAT;
  localparam int DW        = $clog2(DRAIN_CYC + 1);
  localparam logic [DW-1:0]                  D_LAST  = DW'(DRAIN_CYC);
  localparam logic [IDX_WIDTH_FOR_NODES:0]   WB_LAST = (IDX_WIDTH_FOR_NODES+1)'(NUM_NODES);
  localparam logic [ADDR_WIDTH:0]            LEN_N   = (ADDR_WIDTH+1)'(NUM_NODES);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, WB} state_t;

  state_t                       state;
  logic                         src_r;
  logic                         init_r;
  logic [7:0]                   iters_r;
  // one bit wider than the address so a full 2^ADDR_WIDTH stream does not wrap
  logic [ADDR_WIDTH:0]          len_r;
  logic [ADDR_WIDTH:0]          beat;
  logic [DW-1:0]                dcnt;
  logic [IDX_WIDTH_FOR_NODES:0] wcnt;
  logic [RD_LAT-1:0]            fb_pipe;

  logic                           more;
  logic                           iss;
  logic [ADDR_WIDTH-1:0]          iss_addr;
  logic                           iss_src;
  logic                           iss_init;
  logic                           wr;
  logic [IDX_WIDTH_FOR_NODES-1:0] wr_k;

  assign dinsel = 2'b00;
  assign more   = ({1'b0, cur_iter} + 9'd1) < {1'b0, iters_r};

  // Decide which stream beat / writeback slot the next cycle carries. Beat 0
  // is issued from IDLE (new command) or from the last WB cycle (next pass),
  // so the register stage below can present it with no gap.
  always_comb begin
    iss      = 1'b0;
    iss_addr = beat[ADDR_WIDTH-1:0];
    iss_src  = src_r;
    iss_init = init_r && (cur_iter == 8'd0);
    wr       = 1'b0;
    wr_k     = wcnt[IDX_WIDTH_FOR_NODES-1:0];
    case (state)
      IDLE: if (start) begin
        iss      = 1'b1;
        iss_addr = '0;
        iss_src  = cfg_src;
        iss_init = cfg_use_init;
      end
      STREAM: iss = (beat != len_r);
      DRAIN: if (dcnt == D_LAST) begin
        wr   = 1'b1;
        wr_k = '0;
      end
      WB: begin
        if (wcnt != WB_LAST) begin
          wr = 1'b1;
        end else if (more) begin
          iss      = 1'b1;
          iss_addr = '0;
          iss_src  = !src_r;
          iss_init = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Sequencer state plus every registered output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      src_r       <= 1'b0;
      init_r      <= 1'b0;
      iters_r     <= 8'd0;
      len_r       <= '0;
      beat        <= '0;
      dcnt        <= '0;
      wcnt        <= '0;
      fb_pipe     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mbram_en    <= 1'b0;
      mbram_addr  <= '0;
      vbram0_en   <= 1'b0;
      vbram0_we   <= 1'b0;
      vbram0_addr <= '0;
      vbram1_en   <= 1'b0;
      vbram1_we   <= 1'b0;
      vbram1_addr <= '0;
      asel        <= 2'b00;
      csels       <= '0;
      ressel      <= '0;
      cur_iter    <= 8'd0;
    end else begin
      done      <= 1'b0;
      mbram_en  <= 1'b0;
      vbram0_en <= 1'b0;
      vbram0_we <= 1'b0;
      vbram1_en <= 1'b0;
      vbram1_we <= 1'b0;

      // read side: matrix column plus source vector element (unless init feeds the mesh)
      if (iss) begin
        mbram_en   <= 1'b1;
        mbram_addr <= iss_addr;
        asel       <= {iss_init, iss_src};
        if (!iss_src) begin
          vbram0_en   <= !iss_init;
          vbram0_addr <= iss_addr;
        end else begin
          vbram1_en   <= !iss_init;
          vbram1_addr <= iss_addr;
        end
      end

      // write side: destination is always the bank not being read this pass
      if (wr) begin
        ressel <= wr_k;
        if (src_r) begin
          vbram0_en   <= 1'b1;
          vbram0_we   <= 1'b1;
          vbram0_addr <= ADDR_WIDTH'(wr_k);
        end else begin
          vbram1_en   <= 1'b1;
          vbram1_we   <= 1'b1;
          vbram1_addr <= ADDR_WIDTH'(wr_k);
        end
      end

      // first-beat marker delayed by the BRAM latency, then skewed across nodes
      fb_pipe[0] <= iss && (state != STREAM);
      for (int i = 1; i < RD_LAT; i++) fb_pipe[i] <= fb_pipe[i-1];
      csels <= {csels[NUM_NODES-2:0], fb_pipe[RD_LAT-1]};

      case (state)
        IDLE: if (start) begin
          src_r    <= cfg_src;
          init_r   <= cfg_use_init;
          iters_r  <= (cfg_iters == 8'd0) ? 8'd1 : cfg_iters;
          len_r    <= {1'b0, cfg_len_m1} + {{ADDR_WIDTH{1'b0}}, 1'b1};
          cur_iter <= 8'd0;
          beat     <= {{ADDR_WIDTH{1'b0}}, 1'b1};
          busy     <= 1'b1;
          state    <= STREAM;
        end
        STREAM: begin
          if (beat == len_r) begin
            dcnt  <= DW'(1);
            state <= DRAIN;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        DRAIN: begin
          if (dcnt == D_LAST) begin
            wcnt  <= (IDX_WIDTH_FOR_NODES+1)'(1);
            state <= WB;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        WB: begin
          if (wcnt != WB_LAST) begin
            wcnt <= wcnt + 1'b1;
          end else if (more) begin
            cur_iter <= cur_iter + 8'd1;
            src_r    <= !src_r;
            len_r    <= LEN_N;
            beat     <= {{ADDR_WIDTH{1'b0}}, 1'b1};
            state    <= STREAM;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mesh_ctrl.sv
// Directed bench for mesh_ctrl with a 4-node mesh, RD_LAT=1, NODE_LAT=3 (drain 8).
module tb_mesh_ctrl;
  localparam int IW = 2;
  localparam int NN = 4;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] cfg_len_m1 = '0;
  logic [7:0]    cfg_iters = 8'd0;
  logic          cfg_src = 1'b0;
  logic          cfg_use_init = 1'b0;
  logic          busy, done, mbram_en, vbram0_en, vbram0_we, vbram1_en, vbram1_we;
  logic [AW-1:0] mbram_addr, vbram0_addr, vbram1_addr;
  logic [1:0]    asel, dinsel;
  logic [NN-1:0] csels;
  logic [IW-1:0] ressel;
  logic [7:0]    cur_iter;
  logic [63:0]   all_out;

  mesh_ctrl #(.IDX_WIDTH_FOR_NODES(IW), .NUM_NODES(NN), .ADDR_WIDTH(AW),
              .RD_LAT(1), .NODE_LAT(3)) dut (
    .clk(clk), .rstn(rstn), .start(start), .cfg_len_m1(cfg_len_m1),
    .cfg_iters(cfg_iters), .cfg_src(cfg_src), .cfg_use_init(cfg_use_init),
    .busy(busy), .done(done), .mbram_en(mbram_en), .mbram_addr(mbram_addr),
    .vbram0_en(vbram0_en), .vbram0_we(vbram0_we), .vbram0_addr(vbram0_addr),
    .vbram1_en(vbram1_en), .vbram1_we(vbram1_we), .vbram1_addr(vbram1_addr),
    .asel(asel), .csels(csels), .ressel(ressel), .dinsel(dinsel), .cur_iter(cur_iter)
  );

  assign all_out = {9'd0, busy, done, mbram_en, mbram_addr, vbram0_en, vbram0_we,
                    vbram0_addr, vbram1_en, vbram1_we, vbram1_addr, asel, csels,
                    ressel, dinsel, cur_iter};

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [NN-1:0] cs_or;

  typedef struct {
    int          cyc;
    logic        busy, done, m_en;
    logic [AW-1:0] m_addr;
    logic        v0_en, v0_we, v1_en, v1_we;
    logic [AW-1:0] v_addr;
    logic [IW-1:0] ressel;
    logic [NN-1:0] csels;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(input int c, input logic b, input logic d, input logic me,
                              input int ma, input logic v0e, input logic v0w,
                              input logic v1e, input logic v1w, input int va,
                              input int rs, input logic [NN-1:0] cs);
    vec_t v;
    v.cyc = c; v.busy = b; v.done = d; v.m_en = me; v.m_addr = ma[AW-1:0];
    v.v0_en = v0e; v.v0_we = v0w; v.v1_en = v1e; v.v1_we = v1w;
    v.v_addr = va[AW-1:0]; v.ressel = rs[IW-1:0]; v.csels = cs;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (done) done_cnt++;
    cs_or = cs_or | csels;
  endtask

  // call at a negedge; returns sampling cycle 1 of the new run
  task automatic launch(input logic [AW-1:0] lm1, input logic [7:0] it,
                        input logic s, input logic ini);
    cfg_len_m1 = lm1; cfg_iters = it; cfg_src = s; cfg_use_init = ini;
    start = 1'b1;
    cyc = 0; done_cnt = 0; cs_or = '0;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int exp_cyc, input string name);
    while (!done && cyc < exp_cyc + 40) step();
    chk({name, ".done_cycle"}, 64'(cyc), 64'(exp_cyc));
    chk({name, ".done"}, 64'(done), 64'd1);
    chk({name, ".busy_at_done"}, 64'(busy), 64'd0);
  endtask

  task automatic check_vec(input vec_t v);
    chk("single.busy", 64'(busy), 64'(v.busy));
    chk("single.done", 64'(done), 64'(v.done));
    chk("single.mbram_en", 64'(mbram_en), 64'(v.m_en));
    chk("single.vbram0_en", 64'(vbram0_en), 64'(v.v0_en));
    chk("single.vbram0_we", 64'(vbram0_we), 64'(v.v0_we));
    chk("single.vbram1_en", 64'(vbram1_en), 64'(v.v1_en));
    chk("single.vbram1_we", 64'(vbram1_we), 64'(v.v1_we));
    chk("single.csels", 64'(csels), 64'(v.csels));
    if (v.m_en) chk("single.mbram_addr", 64'(mbram_addr), 64'(v.m_addr));
    if (v.v0_en) chk("single.vbram0_addr", 64'(vbram0_addr), 64'(v.v_addr));
    if (v.v1_en) chk("single.vbram1_addr", 64'(vbram1_addr), 64'(v.v_addr));
    if (v.v1_we) chk("single.ressel", 64'(ressel), 64'(v.ressel));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b[$];
    logic prev_we;
    int dcyc;
    logic [7:0] it_at_done;

    // single pass len=4 src=0: reads vbram0, writes vbram1
    tbl[0] = mk(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 4'b0000);
    tbl[1] = mk(2, 1, 0, 1, 1, 1, 0, 0, 0, 1, 0, 4'b0001);
    tbl[2] = mk(3, 1, 0, 1, 2, 1, 0, 0, 0, 2, 0, 4'b0010);
    tbl[3] = mk(4, 1, 0, 1, 3, 1, 0, 0, 0, 3, 0, 4'b0100);
    tbl[4] = mk(5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1000);
    for (int i = 5; i < 12; i++) tbl[i] = mk(i + 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    for (int k = 0; k < 4; k++) tbl[12 + k] = mk(13 + k, 1, 0, 0, 0, 0, 0, 1, 1, k, k, 4'b0000);
    tbl[16] = mk(17, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);

    // reset: start toggled while held in reset has no effect
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); start = ~start;
      chk("reset.outputs", all_out, 64'd0);
    end
    @(negedge clk); start = 1'b0; rstn = 1'b1;
    step(); step();
    chk("reset.released_outputs", all_out, 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);

    // single pass, table-driven
    launch(10'd3, 8'd1, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) begin
      while (cyc < tbl[i].cyc) step();
      check_vec(tbl[i]);
    end

    // three passes from src=1: write banks 0,1,0, one done at cycle 49
    step();
    launch(10'd3, 8'd3, 1'b1, 1'b0);
    prev_we = 1'b0; dcyc = 0; it_at_done = 8'hff;
    while (cyc < 70) begin
      if ((vbram0_we || vbram1_we) && !prev_we) b.push_back(int'(vbram1_we));
      prev_we = vbram0_we || vbram1_we;
      if (done) begin dcyc = cyc; it_at_done = cur_iter; end
      if (cyc == 17) begin
        chk("multi.pass1_asel", 64'(asel), 64'd0);
        chk("multi.pass1_v0_en", 64'(vbram0_en), 64'd1);
      end
      step();
    end
    chk("multi.write_count", 64'(b.size()), 64'd3);
    if (b.size() == 3) begin
      chk("multi.bank0", 64'(b[0]), 64'd0);
      chk("multi.bank1", 64'(b[1]), 64'd1);
      chk("multi.bank2", 64'(b[2]), 64'd0);
    end
    chk("multi.done_count", 64'(done_cnt), 64'd1);
    chk("multi.done_cycle", 64'(dcyc), 64'd49);
    chk("multi.cur_iter", 64'(it_at_done), 64'd2);

    // init feed on pass 0 only
    launch(10'd3, 8'd2, 1'b0, 1'b1);
    while (cyc < 40) begin
      if (cyc >= 1 && cyc <= 4) begin
        chk("init.asel", 64'(asel), 64'b10);
        chk("init.vbram_en", 64'(vbram0_en | vbram1_en), 64'd0);
        chk("init.mbram_en", 64'(mbram_en), 64'd1);
      end
      if (cyc == 17) begin
        chk("init.pass1_asel", 64'(asel), 64'b01);
        chk("init.pass1_v1_en", 64'(vbram1_en), 64'd1);
      end
      step();
    end

    // start during DRAIN is ignored
    launch(10'd3, 8'd1, 1'b0, 1'b0);
    while (cyc < 7) step();
    cfg_iters = 8'd3; start = 1'b1; step(); start = 1'b0;
    wait_done(17, "ignore");
    for (int i = 0; i < 20; i++) step();
    chk("ignore.done_count", 64'(done_cnt), 64'd1);
    chk("ignore.busy_after", 64'(busy), 64'd0);

    // async abort during WB
    launch(10'd3, 8'd1, 1'b0, 1'b0);
    while (cyc < 14) step();
    #2 rstn = 1'b0;
    #1 chk("abort.outputs", all_out, 64'd0);
    step();
    rstn = 1'b1;
    for (int i = 0; i < 25; i++) step();
    chk("abort.no_done", 64'(done_cnt), 64'd0);
    chk("abort.idle_outputs", all_out, 64'd0);

    // len = 1
    launch(10'd0, 8'd1, 1'b0, 1'b0);
    wait_done(14, "len1");
    chk("len1.csels_all", 64'(cs_or), 64'hf);

    // iters = 0 behaves as 1
    step();
    launch(10'd3, 8'd0, 1'b0, 1'b0);
    wait_done(17, "iters0");

    // start sampled in the done cycle
    launch(10'd3, 8'd1, 1'b0, 1'b0);
    chk("restart.busy", 64'(busy), 64'd1);
    chk("restart.mbram_en", 64'(mbram_en), 64'd1);
    wait_done(17, "restart");

    // maximum length: beat counter must not wrap
    step();
    launch(10'h3ff, 8'd1, 1'b0, 1'b0);
    while (cyc < 1024) step();
    chk("maxlen.last_addr", 64'(mbram_addr), 64'd1023);
    chk("maxlen.last_en", 64'(mbram_en), 64'd1);
    step();
    chk("maxlen.drain_en", 64'(mbram_en), 64'd0);
    wait_done(1037, "maxlen");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
